// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared processor register-file parameters and helpers
package operand_fetch_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 32;
  localparam int RA_IDX   = 15;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int CNT_W    = 16;

  typedef logic [IDX_W-1:0]    reg_idx_t;
  typedef logic [REG_W-1:0]    reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef struct packed {
    reg_data_t op1;
    reg_data_t op2;
    reg_idx_t  rd;
  } op_bundle_t;

  function automatic reg_mask_t idx_mask(input reg_idx_t idx);
    reg_mask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Calls always link through the return-address register.
  function automatic reg_idx_t resolve_dest(input logic iscall, input reg_idx_t rd);
    return iscall ? reg_idx_t'(RA_IDX) : rd;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register storage with two combinational read ports and write-through bypass
module regfile_2r1w
  import operand_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_idx_t  ra1,
  output reg_data_t rd1,
  input  reg_idx_t  ra2,
  output reg_data_t rd2,
  input  logic      we,
  input  reg_idx_t  wa,
  input  reg_data_t wd
);

  reg_data_t mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  // A write landing this cycle is visible to readers in the same cycle.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (we && (wa == ra1)) rd1 = wd;
    if (we && (wa == ra2)) rd2 = wd;
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read, scoreboard hazard check and issue/execute handshake
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [IDX_W-1:0] rs1,
  input  logic [IDX_W-1:0] rs2,
  input  logic [1:0]       src_en,
  input  logic [IDX_W-1:0] rd,
  input  logic             iswb,
  input  logic             iscall,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [REG_W-1:0] op1,
  output logic [REG_W-1:0] op2,
  output logic [IDX_W-1:0] op_rd,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [REG_W-1:0] wb_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       wb_act;
  reg_idx_t   dest;
  reg_mask_t  wb_clr;
  reg_mask_t  busy_set;
  reg_mask_t  busy_live;
  logic       hazard;
  logic       accept;
  reg_data_t  rf_rd1;
  reg_data_t  rf_rd2;
  op_bundle_t next_op;

  assign wb_act = wb_en && !rst;

  regfile_2r1w u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .rd1 (rf_rd1),
    .ra2 (rs2),
    .rd2 (rf_rd2),
    .we  (wb_act),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // A register being written back this cycle no longer blocks issue.
  always_comb begin
    dest      = resolve_dest(iscall, rd);
    wb_clr    = wb_act ? idx_mask(wb_addr) : '0;
    busy_live = busy_mask & ~wb_clr;
    hazard    = (src_en[0] && busy_live[rs1]) ||
                (src_en[1] && busy_live[rs2]) ||
                (iswb && busy_live[dest]);
    issue_ready = !rst && !hazard && (!op_valid || op_ready);
    accept      = issue_valid && issue_ready;
    busy_set    = (accept && iswb) ? idx_mask(dest) : '0;
    next_op.op1 = src_en[0] ? rf_rd1 : '0;
    next_op.op2 = src_en[1] ? rf_rd2 : '0;
    next_op.rd  = dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid  <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      op_rd     <= '0;
      busy_mask <= '0;
      stall_cnt <= '0;
    end else begin
      // Set is applied after clear so a same-cycle issue keeps its destination busy.
      busy_mask <= (busy_mask & ~wb_clr) | busy_set;
      if (accept) begin
        op_valid <= 1'b1;
        op1      <= next_op.op1;
        op2      <= next_op.op2;
        op_rd    <= next_op.rd;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
      if (issue_valid && hazard && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch against a register-level reference model
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  rs1, rs2, rd, op_rd, wb_addr;
  logic [1:0]  src_en;
  logic        iswb, iscall, op_valid, op_ready, wb_en;
  logic [31:0] op1, op2, wb_data;
  logic [15:0] busy_mask, stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_regs [16];
  logic [15:0] m_busy;
  logic        m_op_valid;
  logic [31:0] m_op1, m_op2;
  logic [3:0]  m_op_rd;
  logic [15:0] m_stall;
  logic        last_ready;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .src_en(src_en), .rd(rd), .iswb(iswb), .iscall(iscall),
    .op_valid(op_valid), .op_ready(op_ready), .op1(op1), .op2(op2), .op_rd(op_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the combinational ready, advance, check registered state.
  task automatic cyc(input logic i_rst, input logic iv, input logic [3:0] r1, input logic [3:0] r2,
                     input logic [1:0] se, input logic [3:0] d, input logic w, input logic c,
                     input logic ordy, input logic we, input logic [3:0] wa, input logic [31:0] wd);
    logic [3:0]  dst;
    logic [15:0] live;
    logic        haz, exp_ready, acc;
    logic [31:0] v1, v2;
    rst = i_rst; issue_valid = iv; rs1 = r1; rs2 = r2; src_en = se; rd = d;
    iswb = w; iscall = c; op_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    dst  = c ? 4'd15 : d;
    live = m_busy;
    if (we) live[wa] = 1'b0;
    haz = (se[0] && live[r1]) || (se[1] && live[r2]) || (w && live[dst]);
    exp_ready = !i_rst && !haz && (!m_op_valid || ordy);
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ready});
    last_ready = issue_ready;
    v1 = !se[0] ? 32'd0 : (we && wa == r1) ? wd : m_regs[r1];
    v2 = !se[1] ? 32'd0 : (we && wa == r2) ? wd : m_regs[r2];
    @(posedge clk);
    if (i_rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_busy = 16'd0; m_op_valid = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_op_rd = 4'd0; m_stall = 16'd0;
    end else begin
      acc = iv && exp_ready;
      if (iv && haz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (acc) begin
        m_op_valid = 1'b1; m_op1 = v1; m_op2 = v2; m_op_rd = dst;
      end else if (ordy) begin
        m_op_valid = 1'b0;
      end
      if (we) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (acc && w) m_busy[dst] = 1'b1;
    end
    @(negedge clk);
    chk("op_valid", {31'd0, op_valid}, {31'd0, m_op_valid});
    chk("op1", op1, m_op1);
    chk("op2", op2, m_op2);
    chk("op_rd", {28'd0, op_rd}, {28'd0, m_op_rd});
    chk("busy_mask", {16'd0, busy_mask}, {16'd0, m_busy});
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
  endtask

  task automatic idle(input logic ordy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] h1, h2;
    logic [3:0]  hrd;
    logic [15:0] s0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_busy = 16'd0; m_op_valid = 1'b0; m_op1 = 32'd0; m_op2 = 32'd0; m_op_rd = 4'd0; m_stall = 16'd0;

    // Reset with issue and write-back offered: both must be ignored.
    cyc(1, 1, 1, 2, 2'b11, 3, 1, 0, 1, 1, 4, 32'h1111_2222);
    chk("reset_ready", {31'd0, last_ready}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("reset_busy", {16'd0, busy_mask}, 32'd0);

    // Fresh issue reads zeros.
    cyc(0, 1, 3, 4, 2'b11, 1, 0, 0, 1, 0, 0, 0);
    chk("first_op1", op1, 32'd0);
    chk("first_op2", op2, 32'd0);
    chk("first_valid", {31'd0, op_valid}, 32'd1);
    chk("first_busy", {16'd0, busy_mask}, 32'd0);

    // Write-through bypass.
    cyc(0, 1, 5, 0, 2'b01, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF);
    chk("bypass_op1", op1, 32'hDEAD_BEEF);
    chk("unused_op2", op2, 32'd0);

    // RAW hazard: stall until the write-back, then accept with the bypassed value.
    cyc(0, 1, 0, 0, 2'b00, 2, 1, 0, 1, 0, 0, 0);
    s0 = stall_cnt;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 2, 0, 2'b01, 0, 0, 0, 1, 0, 0, 0);
      chk("raw_stall_ready", {31'd0, last_ready}, 32'd0);
    end
    chk("raw_stall_cnt", {16'd0, stall_cnt}, {16'd0, s0 + 16'd3});
    cyc(0, 1, 2, 0, 2'b01, 0, 0, 0, 1, 1, 2, 32'h1234_5678);
    chk("raw_release_ready", {31'd0, last_ready}, 32'd1);
    chk("raw_release_op1", op1, 32'h1234_5678);

    // Call forces destination r15.
    cyc(0, 1, 0, 0, 2'b00, 7, 1, 1, 1, 0, 0, 0);
    chk("call_op_rd", {28'd0, op_rd}, 32'd15);
    chk("call_busy", {16'd0, busy_mask}, 32'h0000_8000);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 15, 32'hA5A5_0F0F);

    // Backpressure holds the bundle and blocks issue.
    cyc(0, 1, 5, 15, 2'b11, 3, 0, 0, 1, 0, 0, 0);
    h1 = op1; h2 = op2; hrd = op_rd;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 2, 2, 2'b11, 4, 0, 0, 0, 0, 0, 0);
      chk("bp_ready", {31'd0, last_ready}, 32'd0);
      chk("bp_op1_hold", op1, h1);
      chk("bp_op2_hold", op2, h2);
      chk("bp_rd_hold", {28'd0, op_rd}, {28'd0, hrd});
    end
    cyc(0, 1, 2, 2, 2'b11, 4, 0, 0, 1, 0, 0, 0);
    chk("bp_release_ready", {31'd0, last_ready}, 32'd1);
    chk("bp_release_op1", op1, 32'h1234_5678);

    // Same-cycle set and clear of r9: set wins.
    cyc(0, 1, 0, 0, 2'b00, 9, 1, 0, 1, 1, 9, 32'h0000_0909);
    chk("set_wins_bit9", {31'd0, busy_mask[9]}, 32'd1);

    // Reset discards an in-flight bundle.
    cyc(0, 1, 9, 0, 2'b01, 1, 0, 0, 0, 1, 9, 32'h7);
    cyc(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    chk("midreset_valid", {31'd0, op_valid}, 32'd0);
    idle(1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0,
          4'($urandom), 4'($urandom), 2'($urandom), 4'($urandom),
          1'($urandom), $urandom_range(7) == 0, $urandom_range(3) != 0,
          1'($urandom), 4'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
